// File: rtl/block_averaging_pkg.sv
// block_averaging_pkg: shared image defaults, zoom codes and FSM state encoding.
package block_averaging_pkg;
    localparam int IMG_WIDTH_DEF  = 160;
    localparam int IMG_HEIGHT_DEF = 120;
    localparam logic [2:0] ZOOM_QUARTER = 3'd0;
    localparam logic [2:0] ZOOM_HALF    = 3'd1;
    localparam logic [2:0] ZOOM_COPY    = 3'd2;
    typedef enum logic [2:0] {IDLE, READ, LAST, WRITE, DONE} state_e;
    function automatic logic [1:0] zoom_to_k(input logic [2:0] z);
        return z >= ZOOM_COPY ? 2'd0 : z == ZOOM_HALF ? 2'd1 : 2'd2;
    endfunction
endpackage

// File: rtl/block_averaging_if.sv
// block_averaging_if: memory-side and control signals of the block averager.
interface block_averaging_if;
    logic        enable;
    logic [2:0]  zoom_level;
    logic [7:0]  pixel_in;
    logic [14:0] read_addr;
    logic [7:0]  pixel_out;
    logic [18:0] write_addr;
    logic        write_en;
    logic        done;
    modport master (output enable, zoom_level, pixel_in,
                    input  read_addr, pixel_out, write_addr, write_en, done);
    modport slave  (input  enable, zoom_level, pixel_in,
                    output read_addr, pixel_out, write_addr, write_en, done);
endinterface

// File: rtl/block_addr_gen.sv
// block_addr_gen: block/pixel counters with registered source and destination addresses.
module block_addr_gen
    import block_averaging_pkg::*;
#(
    parameter int IMG_WIDTH_IN  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT_IN = IMG_HEIGHT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        rd_step_i,
    input  logic        px_next_i,
    input  logic        wr_load_i,
    input  logic [1:0]  k_i,
    output logic [14:0] read_addr_o,
    output logic [18:0] write_addr_o,
    output logic        last_rd_o,
    output logic        last_px_o
);
    logic [7:0]  x_q, x_d, y_q, y_d;
    logic [1:0]  dx_q, dx_d, dy_q, dy_d, n_m1;
    logic [18:0] px_q, px_d, wa_q, wa_d, px_last;
    logic [14:0] ra_q, ra_d;
    logic [7:0]  x_last;
    logic        x_wrap, dx_wrap;
    assign n_m1      = 2'((1 << k_i) - 1);
    assign x_last    = 8'((IMG_WIDTH_IN >> k_i) - 1);
    assign px_last   = 19'((IMG_WIDTH_IN >> k_i) * (IMG_HEIGHT_IN >> k_i) - 1);
    assign x_wrap    = x_q == x_last;
    assign dx_wrap   = dx_q == n_m1;
    assign last_rd_o = dx_wrap && dy_q == n_m1;
    assign last_px_o = px_q == px_last;
    // the final pixel wraps every counter to zero so read_addr stays in range
    always_comb begin
        x_d  = start_i || (px_next_i && x_wrap) ? '0 : px_next_i ? x_q + 8'd1 : x_q;
        y_d  = start_i || (px_next_i && last_px_o) ? '0 : px_next_i && x_wrap ? y_q + 8'd1 : y_q;
        dx_d = start_i || px_next_i || (rd_step_i && dx_wrap) ? '0 : rd_step_i ? dx_q + 2'd1 : dx_q;
        dy_d = start_i || px_next_i ? '0 : rd_step_i && dx_wrap ? dy_q + 2'd1 : dy_q;
        px_d = start_i || (px_next_i && last_px_o) ? '0 : px_next_i ? px_q + 19'd1 : px_q;
        wa_d = wr_load_i ? px_q : wa_q;
        ra_d = 15'((((32'(y_d) << k_i) + 32'(dy_d)) * IMG_WIDTH_IN) + (32'(x_d) << k_i) + 32'(dx_d));
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q  <= '0;
            y_q  <= '0;
            dx_q <= '0;
            dy_q <= '0;
            px_q <= '0;
            wa_q <= '0;
            ra_q <= '0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
            px_q <= px_d;
            wa_q <= wa_d;
            ra_q <= ra_d;
        end
    end
    assign read_addr_o  = ra_q;
    assign write_addr_o = wa_q;
endmodule

// File: rtl/block_averaging.sv
// block_averaging: downscales an image by averaging NxN blocks read from source memory.
module block_averaging
    import block_averaging_pkg::*;
#(
    parameter int IMG_WIDTH_IN  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT_IN = IMG_HEIGHT_DEF
) (
    input logic              clk,
    input logic              reset,
    block_averaging_if.slave bus
);
    state_e      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [11:0] acc_q, acc_d, sum;
    logic [7:0]  pix_q, pix_d;
    logic        valid_q;
    logic        start, rd_step, px_next, wr_load, last_rd, last_px;
    assign start   = state_q == IDLE && bus.enable;
    assign rd_step = state_q == READ && bus.enable && !last_rd;
    assign px_next = state_q == WRITE && bus.enable;
    assign wr_load = state_q == LAST && bus.enable;
    assign sum     = acc_q + 12'(bus.pixel_in);
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = READ;
            READ:    state_d = last_rd ? LAST : READ;
            LAST:    state_d = WRITE;
            WRITE:   state_d = last_px ? DONE : READ;
            default: state_d = DONE;
        endcase
        if (!bus.enable) state_d = IDLE;
        k_d   = start ? zoom_to_k(bus.zoom_level) : k_q;
        // valid_q marks cycles whose pixel_in answers the previous cycle's read_addr
        acc_d = start || state_q == WRITE ? '0 : valid_q ? sum : acc_q;
        pix_d = wr_load ? 8'(sum >> {k_q, 1'b0}) : pix_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            pix_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            pix_q   <= pix_d;
            valid_q <= state_q == READ;
        end
    end
    block_addr_gen #(
        .IMG_WIDTH_IN (IMG_WIDTH_IN),
        .IMG_HEIGHT_IN(IMG_HEIGHT_IN)
    ) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start),
        .rd_step_i   (rd_step),
        .px_next_i   (px_next),
        .wr_load_i   (wr_load),
        .k_i         (k_q),
        .read_addr_o (bus.read_addr),
        .write_addr_o(bus.write_addr),
        .last_rd_o   (last_rd),
        .last_px_o   (last_px)
    );
    assign bus.pixel_out = pix_q;
    assign bus.write_en  = state_q == WRITE;
    assign bus.done      = state_q == DONE;
endmodule

// File: tb/tb_block_averaging.sv
// tb_block_averaging: random and directed frames checked against a block-average reference model.
module tb_block_averaging;
    localparam int W = 32;
    localparam int H = 24;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    block_averaging_if bus ();
    block_averaging #(.IMG_WIDTH_IN(W), .IMG_HEIGHT_IN(H)) dut (.clk(clk), .reset(reset), .bus(bus));
    logic [7:0]  mem [0:32767];
    logic [26:0] wq [$];
    int          wt [$];
    logic [7:0]  exp_q [$];
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    bit arm = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.pixel_in <= mem[bus.read_addr];
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask
    always @(negedge clk) begin
        if (bus.write_en === 1'b1) begin
            wq.push_back({bus.write_addr, bus.pixel_out});
            wt.push_back(cyc);
        end
        if (arm) chk("read_addr_range", 64'(bus.read_addr < 15'(W * H)), 64'd1);
    end
    task automatic step();
        @(negedge clk);
        #1;
    endtask
    function automatic int kof(input logic [2:0] z);
        return z == 3'd0 ? 2 : z == 3'd1 ? 1 : 0;
    endfunction
    // expected frame: mean of each NxN tile of the image, truncated
    task automatic build_exp(input int k);
        int n, sum;
        n = 1 << k;
        exp_q.delete();
        for (int yo = 0; yo < (H >> k); yo++)
            for (int xo = 0; xo < (W >> k); xo++) begin
                sum = 0;
                for (int y = yo * n; y < yo * n + n; y++)
                    for (int x = xo * n; x < xo * n + n; x++) sum += int'(mem[y * W + x]);
                exp_q.push_back(8'(sum / (n * n)));
            end
    endtask
    task automatic check_writes(input int cnt, input int nn, input int start);
        int prev;
        prev = start;
        for (int i = 0; i < cnt && i < wq.size(); i++) begin
            chk("write_addr_pixel_gap", 64'({wq[i], 32'(wt[i] - prev)}), 64'({19'(i), exp_q[i], 32'(nn + 2)}));
            prev = wt[i];
        end
    endtask
    task automatic run_frame(input logic [2:0] zl, input logic [2:0] zl_mid, input int mid_at);
        int k, nn, p, start;
        bit seen;
        k = kof(zl);
        nn = 1 << (2 * k);
        p = (W >> k) * (H >> k);
        build_exp(k);
        wq.delete();
        wt.delete();
        bus.zoom_level = zl;
        bus.enable = 1'b1;
        start = cyc;
        seen = 1'b0;
        for (int i = 0; i < p * (nn + 2) + 20 && !seen; i++) begin
            step();
            if (i == mid_at) bus.zoom_level = zl_mid;
            seen = bus.done === 1'b1;
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("done_time", 64'(cyc - start), 64'(1 + p * (nn + 2)));
        chk("write_count", 64'(wq.size()), 64'(p));
        check_writes(p, nn, start);
        repeat (3) step();
        chk("done_hold", 64'({bus.done, bus.write_en}), 64'(2'b10));
        chk("no_extra_writes", 64'(wq.size()), 64'(p));
        bus.enable = 1'b0;
        step();
        chk("done_clear", 64'(bus.done), 64'd0);
    endtask
    task automatic fill_random();
        for (int a = 0; a < W * H; a++) mem[a] = 8'($urandom);
    endtask
    initial begin
        int start;
        logic [2:0] zl;
        bus.enable = 1'b0;
        bus.zoom_level = 3'd0;
        for (int a = 0; a < 32768; a++) mem[a] = 8'h00;
        repeat (2) step();
        chk("reset_outputs", 64'({bus.read_addr, bus.write_addr, bus.pixel_out, bus.write_en, bus.done}), 64'd0);
        reset = 1'b0;
        arm = 1'b1;
        step();
        for (int a = 0; a < W * H; a++) mem[a] = 8'h40;
        run_frame(3'd1, 3'd1, -1);
        for (int a = 0; a < W * H; a++) mem[a] = 8'(a & 15);
        run_frame(3'd0, 3'd0, -1);
        chk("gradient_first_pixel", 64'(wq.size() > 0 ? wq[0][7:0] : 8'hxx), 64'd1);
        for (int a = 0; a < W * H; a++) mem[a] = 8'hFF;
        run_frame(3'd0, 3'd0, -1);
        for (int a = 0; a < W * H; a++) mem[a] = 8'(a);
        run_frame(3'd4, 3'd4, -1);
        for (int r = 0; r < 3; r++) begin
            fill_random();
            zl = 3'($urandom_range(0, 7));
            run_frame(zl, zl, -1);
        end
        fill_random();
        run_frame(3'd1, 3'd0, 40);
        fill_random();
        run_frame(3'd0, 3'd5, 100);
        fill_random();
        build_exp(1);
        wq.delete();
        wt.delete();
        bus.zoom_level = 3'd1;
        bus.enable = 1'b1;
        for (int i = 0; i < 5000 && wq.size() < 100; i++) step();
        chk("abort_reached_100", 64'(wq.size()), 64'd100);
        reset = 1'b1;
        step();
        chk("reset_abort_outputs", 64'({bus.read_addr, bus.write_addr, bus.pixel_out, bus.write_en, bus.done}), 64'd0);
        repeat (3) step();
        chk("reset_no_write", 64'(wq.size()), 64'd100);
        wq.delete();
        wt.delete();
        start = cyc;
        reset = 1'b0;
        for (int i = 0; i < 3000 && wq.size() < 50; i++) step();
        chk("restart_reached_50", 64'(wq.size()), 64'd50);
        bus.enable = 1'b0;
        step();
        chk("enable_abort_outputs", 64'({bus.write_en, bus.done}), 64'd0);
        repeat (4) step();
        chk("enable_abort_no_write", 64'(wq.size()), 64'd50);
        check_writes(50, 4, start);
        run_frame(3'd1, 3'd1, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
